// File: rtl/test_03_pkg.sv
// Shared constants and helpers for the test_03 carry-save adder slice.
package test_03_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Width of sum + (carry << 1) for three WIDTH-bit operands.
  function automatic int unsigned total_width(input int unsigned width);
    return width + 2;
  endfunction

endpackage

// File: rtl/test_03_csa_bit.sv
// 1-bit 3:2 compressor (full adder without carry chaining), purely combinational.
module csa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/test_03.sv
// Registered carry-save adder: a + b + c == sum + 2*carry, one cycle latency.
// Optional registered final add (total/total_valid) under macro TEST_03_FINAL_ADD_EN.
module test_03
  import test_03_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
`ifdef TEST_03_FINAL_ADD_EN
  ,
  output logic [total_width(WIDTH)-1:0] total,
  output logic                          total_valid
`endif
);

  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH-1:0] carry_comb;

  for (genvar i = 0; i < WIDTH; i++) begin : g_csa
    csa_bit u_csa_bit (
      .a    (a[i]),
      .b    (b[i]),
      .c    (c[i]),
      .sum  (sum_comb[i]),
      .carry(carry_comb[i])
    );
  end

  // Results hold while in_valid is low; only out_valid tracks every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_comb;
        carry <= carry_comb;
      end
    end
  end

`ifdef TEST_03_FINAL_ADD_EN
  localparam int unsigned TW = total_width(WIDTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_valid <= 1'b0;
      total       <= '0;
    end else begin
      total_valid <= out_valid;
      if (out_valid) begin
        total <= TW'(sum) + (TW'(carry) << 1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_test_03.sv
// Self-checking bench for test_03 at WIDTH=8 and WIDTH=16 (TEST_03_FINAL_ADD_EN optional).
module tb_test_03;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic [7:0]  a8, b8, c8;
  logic [15:0] a16, b16, c16;

  logic        ov8, ov16;
  logic [7:0]  sum8, carry8;
  logic [15:0] sum16, carry16;
`ifdef TEST_03_FINAL_ADD_EN
  logic [9:0]  total8;
  logic [17:0] total16;
  logic        tv8, tv16;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic        ev;
  logic [63:0] es8, ec8, es16, ec16, ops8, ops16;
`ifdef TEST_03_FINAL_ADD_EN
  logic        etv;
  logic [63:0] et8, et16;
`endif

  always #5 clk = ~clk;

  test_03 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .a(a8), .b(b8), .c(c8),
    .out_valid(ov8), .sum(sum8), .carry(carry8)
`ifdef TEST_03_FINAL_ADD_EN
    , .total(total8), .total_valid(tv8)
`endif
  );

  test_03 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .a(a16), .b(b16), .c(c16),
    .out_valid(ov16), .sum(sum16), .carry(carry16)
`ifdef TEST_03_FINAL_ADD_EN
    , .total(total16), .total_valid(tv16)
`endif
  );

  // Per bit: count the ones; the parity is the sum bit, count >= 2 is the carry bit.
  function automatic void csa_model(input logic [63:0] x, input logic [63:0] y,
                                    input logic [63:0] z, input int unsigned w,
                                    output logic [63:0] s, output logic [63:0] cy);
    s  = '0;
    cy = '0;
    for (int unsigned i = 0; i < w; i++) begin
      int unsigned n;
      n = int'(x[i]) + int'(y[i]) + int'(z[i]);
      s[i]  = (n % 2) == 1;
      cy[i] = n >= 2;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs present at the coming edge, then step past it.
  task automatic tick();
    logic [63:0] s, cy;
    if (!rst_n) begin
      ev = 1'b0; es8 = '0; ec8 = '0; es16 = '0; ec16 = '0;
`ifdef TEST_03_FINAL_ADD_EN
      etv = 1'b0; et8 = '0; et16 = '0;
`endif
    end else begin
`ifdef TEST_03_FINAL_ADD_EN
      if (ev) begin
        et8  = es8 + (ec8 << 1);
        et16 = es16 + (ec16 << 1);
      end
      etv = ev;
`endif
      ev = iv;
      if (iv) begin
        csa_model(64'(a8), 64'(b8), 64'(c8), 8, s, cy);
        es8 = s; ec8 = cy;
        csa_model(64'(a16), 64'(b16), 64'(c16), 16, s, cy);
        es16 = s; ec16 = cy;
        ops8  = 64'(a8) + 64'(b8) + 64'(c8);
        ops16 = 64'(a16) + 64'(b16) + 64'(c16);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ov8"},     64'(ov8),     64'(ev));
    chk({tag, "_sum8"},    64'(sum8),    es8);
    chk({tag, "_carry8"},  64'(carry8),  ec8);
    chk({tag, "_ov16"},    64'(ov16),    64'(ev));
    chk({tag, "_sum16"},   64'(sum16),   es16);
    chk({tag, "_carry16"}, 64'(carry16), ec16);
    if (ev) begin
      chk({tag, "_inv8"},  64'(sum8) + 2 * 64'(carry8),   ops8);
      chk({tag, "_inv16"}, 64'(sum16) + 2 * 64'(carry16), ops16);
    end
`ifdef TEST_03_FINAL_ADD_EN
    chk({tag, "_tv8"},     64'(tv8),     64'(etv));
    chk({tag, "_total8"},  64'(total8),  et8);
    chk({tag, "_tv16"},    64'(tv16),    64'(etv));
    chk({tag, "_total16"}, 64'(total16), et16);
`endif
  endtask

  task automatic rand_ops();
    a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); c16 = 16'($urandom);
  endtask

  initial begin
    // Reset overrides a simultaneous in_valid=1
    rst_n = 1'b0; iv = 1'b1; rand_ops();
    tick();
    check_all("reset");
    chk("reset_ov8_zero", 64'(ov8), 64'd0);

    // Directed vectors
    rst_n = 1'b1; iv = 1'b1;
    a8 = 8'hA3; b8 = 8'hD2; c8 = 8'hDD;
    a16 = 16'd4231; b16 = 16'd7642; c16 = 16'd3254;
    tick();
    check_all("dir");
    chk("dir_sum8_const",    64'(sum8),    64'hAC);
    chk("dir_carry8_const",  64'(carry8),  64'hD3);
    chk("dir_sum16_const",   64'(sum16),   64'h01EB);
    chk("dir_carry16_const", 64'(carry16), 64'h1C96);
    iv = 1'b0; rand_ops();
    tick();
    check_all("dir_hold");
    chk("dir_hold_sum8", 64'(sum8), 64'hAC);
`ifdef TEST_03_FINAL_ADD_EN
    chk("dir_total8_const",  64'(total8),  64'd594);
    chk("dir_total16_const", 64'(total16), 64'd15127);
`endif

    // All-ones boundary
    iv = 1'b1;
    a8 = '1; b8 = '1; c8 = '1; a16 = '1; b16 = '1; c16 = '1;
    tick();
    check_all("ones");
    chk("ones_sum8",   64'(sum8),   64'hFF);
    chk("ones_carry8", 64'(carry8), 64'hFF);
    a8 = '0; b8 = '0; c8 = '0; a16 = '0; b16 = '0; c16 = '0;
    tick();
    check_all("zeros");
    chk("zeros_sum16", 64'(sum16), 64'd0);
`ifdef TEST_03_FINAL_ADD_EN
    chk("ones_total8_const", 64'(total8), 64'h2FD);
`endif

    // Back-to-back stream then idle hold
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; rand_ops();
      tick();
      check_all("stream");
    end
    for (int i = 0; i < 2; i++) begin
      iv = 1'b0; rand_ops();
      tick();
      check_all("idle");
    end

    // Mid-stream reset discards in-flight result
    iv = 1'b1; rand_ops();
    tick();
    check_all("pre_rst");
    rst_n = 1'b0; iv = 1'b1; rand_ops();
    tick();
    check_all("mid_rst");
    chk("mid_rst_sum16_zero", 64'(sum16), 64'd0);
    rst_n = 1'b1; iv = 1'b0; rand_ops();
    tick();
    check_all("post_rst_idle");
    iv = 1'b1; rand_ops();
    tick();
    check_all("post_rst_first");

    // Random soak
    for (int i = 0; i < 1000; i++) begin
      iv = ($urandom_range(0, 7) != 0);
      rand_ops();
      tick();
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
